// File: rtl/psum_feed_buf.sv
// rtl/psum_feed_buf.sv - partial-sum feedback buffer between kernel controller, adder-tree column and output writer
// Optional build macro: PSUM_RELU_EN (clamp negative results pushed into the output FIFO to zero)
module psum_feed_buf #(
    parameter int DWIDTH    = 25,
    parameter int DEPTH     = 16,
    parameter int ADD_LAT   = 2,
    parameter int OUT_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       rd_en,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    input  logic                       pass_first,
    input  logic                       pass_last,
    output logic                       rd_ready,
    output logic signed [DWIDTH-1:0]   psum_in,
    input  logic signed [DWIDTH-1:0]   psum_ret,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [DWIDTH-1:0]   out_data
);

    localparam int AW  = $clog2(DEPTH);
    // Stages between issue and the cycle psum_ret carries that issue's result
    localparam int NST = ADD_LAT + 1;
    localparam int CW  = $clog2(OUT_DEPTH + 1);
    localparam int PW  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    // Wide enough for fifo_count + every delay stage holding a last-pass op
    localparam int SW  = $clog2(OUT_DEPTH + NST + 1);

    // Psum storage; deliberately not reset, every tile starts with a first pass
    logic signed [DWIDTH-1:0] mem [DEPTH];

    // Delay line tracking each accepted issue until its adder-tree result returns
    logic [NST-1:0] dl_vld;
    logic [NST-1:0] dl_last;
    logic [AW-1:0]  dl_addr [NST];

    // Output FIFO
    logic signed [DWIDTH-1:0] fifo_mem [OUT_DEPTH];
    logic [PW-1:0]            wr_ptr;
    logic [PW-1:0]            rd_ptr;
    logic [CW-1:0]            fifo_count;

    logic                     accept;
    logic                     wb_mem;
    logic                     push;
    logic                     pop;
    logic [AW-1:0]            wb_addr;
    logic signed [DWIDTH-1:0] push_data;
    logic [SW-1:0]            inflight_last;

    assign accept  = rd_en & rd_ready;
    assign wb_addr = dl_addr[NST-1];
    assign wb_mem  = dl_vld[NST-1] & ~dl_last[NST-1];
    assign push    = dl_vld[NST-1] &  dl_last[NST-1];
    assign pop     = out_valid & out_ready;

`ifdef PSUM_RELU_EN
    assign push_data = psum_ret[DWIDTH-1] ? '0 : psum_ret;
`else
    assign push_data = psum_ret;
`endif

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Count last-pass ops still in the delay line; each will need one FIFO slot
    always_comb begin
        inflight_last = '0;
        for (int i = 0; i < NST; i++) begin
            inflight_last = inflight_last + SW'(dl_vld[i] & dl_last[i]);
        end
    end

    // Credit check reserves a FIFO slot for every in-flight last-pass result,
    // so the tree output is never dropped and the FIFO never overflows
    assign rd_ready = (SW'(fifo_count) + inflight_last) < SW'(OUT_DEPTH);

    // Shift issue tags down the delay line in step with the adder tree
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dl_vld  <= '0;
            dl_last <= '0;
            for (int i = 0; i < NST; i++) begin
                dl_addr[i] <= '0;
            end
        end else begin
            dl_vld[0]  <= accept;
            dl_last[0] <= accept & pass_last;
            dl_addr[0] <= rd_addr;
            for (int i = 1; i < NST; i++) begin
                dl_vld[i]  <= dl_vld[i-1];
                dl_last[i] <= dl_last[i-1];
                dl_addr[i] <= dl_addr[i-1];
            end
        end
    end

    // Register the operand for the tree: zero on first pass, forwarded result
    // when the same entry is being written back this cycle, else stored psum
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            psum_in <= '0;
        end else if (accept) begin
            if (pass_first) begin
                psum_in <= '0;
            end else if (wb_mem && (wb_addr == rd_addr)) begin
                psum_in <= psum_ret;
            end else begin
                psum_in <= mem[rd_addr];
            end
        end
    end

    // Write intermediate-pass results back for the next input-channel pass
    always_ff @(posedge clk) begin
        if (wb_mem) begin
            mem[wb_addr] <= psum_ret;
        end
    end

    // Output FIFO: final-pass results in issue order, head visible on out_data
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= push_data;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + CW'(1);
            end else if (!push && pop) begin
                fifo_count <= fifo_count - CW'(1);
            end
        end
    end

    assign out_valid = (fifo_count != '0);
    assign out_data  = fifo_mem[rd_ptr];

endmodule

// File: tb/tb_psum_feed_buf.sv
// tb/tb_psum_feed_buf.sv - self-checking bench for psum_feed_buf
module tb_psum_feed_buf;

    localparam int DW    = 25;
    localparam int DEPTH = 16;
    localparam int AL    = 2;
    localparam int OD    = 4;
    localparam int AW    = 4;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 rd_en = 1'b0;
    logic [AW-1:0]        rd_addr = '0;
    logic                 pass_first = 1'b0;
    logic                 pass_last = 1'b0;
    logic                 rd_ready;
    logic signed [DW-1:0] psum_in;
    logic signed [DW-1:0] psum_ret;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic signed [DW-1:0] out_data;

    // Adder-tree model: result = operand delayed AL cycles + per-issue addend
    logic signed [DW-1:0] tree_add = '0;
    logic signed [DW-1:0] tp [AL];
    logic signed [DW-1:0] ta [AL+1];

    typedef struct {
        logic [AW-1:0] addr;
        logic          first;
        logic          last;
        int            addend;
        int            exp_in;
        int            exp_out;
    } rec_t;

    rec_t tbl[$];
    int   exp_q[$];
    int   total = 0;
    int   bad = 0;

    psum_feed_buf #(
        .DWIDTH(DW), .DEPTH(DEPTH), .ADD_LAT(AL), .OUT_DEPTH(OD)
    ) dut (
        .clk(clk), .rstn(rstn), .rd_en(rd_en), .rd_addr(rd_addr),
        .pass_first(pass_first), .pass_last(pass_last), .rd_ready(rd_ready),
        .psum_in(psum_in), .psum_ret(psum_ret), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tp[0] <= psum_in;
        for (int i = 1; i < AL; i++) tp[i] <= tp[i-1];
        ta[0] <= tree_add;
        for (int i = 1; i <= AL; i++) ta[i] <= ta[i-1];
    end

    assign psum_ret = tp[AL-1] + ta[AL];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ro(input int v);
`ifdef PSUM_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    function automatic rec_t mk(input int a, input bit f, input bit l,
                                input int add, input int ein, input int eout);
        rec_t r;
        r.addr = AW'(a); r.first = f; r.last = l;
        r.addend = add; r.exp_in = ein; r.exp_out = eout;
        return r;
    endfunction

    // Output scoreboard: compare every popped word against the expected queue
    always @(negedge clk) begin
        if (rstn && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out_unexpected: got %0d expected none", int'(out_data));
            end else begin
                check("out_data", int'(out_data), exp_q.pop_front());
            end
        end
    end

    // Issue one op, waiting (bounded) for credit; checks psum_in after accept
    task automatic issue(input rec_t r, input bit rnd);
        int n = 0;
        rd_en = 1'b1; rd_addr = r.addr; pass_first = r.first;
        pass_last = r.last; tree_add = DW'(r.addend);
        if (rnd) out_ready = ($urandom_range(0, 1) == 1);
        while (!rd_ready && n < 50) begin
            @(posedge clk); #1;
            if (rnd) out_ready = ($urandom_range(0, 1) == 1);
            n++;
        end
        if (!rd_ready) begin
            check("issue_timeout", 0, 1);
            rd_en = 1'b0;
        end else begin
            @(posedge clk); #1;
            rd_en = 1'b0; tree_add = '0;
            check("psum_in", int'(psum_in), r.exp_in);
            if (r.last) exp_q.push_back(r.exp_out);
        end
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        check("drain_left", exp_q.size(), 0);
        check("drain_empty", int'(out_valid), 0);
    endtask

    initial begin
        int sp[4];
        sp = '{5, -7, 100, 0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_psum_in", int'(psum_in), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        rstn = 1'b1;
        #1;
        check("rst_rd_ready", int'(rd_ready), 1);

        // Single-pass mode and three-pass accumulate, table driven
        for (int i = 0; i < 4; i++) tbl.push_back(mk(i, 1, 1, sp[i], 0, ro(sp[i])));
        for (int p = 0; p < 3; p++)
            for (int a = 0; a < 8; a++)
                tbl.push_back(mk(a, p == 0, p == 2, 10, 10 * p, 30));
        out_ready = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < tbl.size(); i++) issue(tbl[i], 1'b0);
        drain();

        // Backpressure: four last-pass issues exhaust credit
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) issue(mk(8 + i, 1, 1, i + 1, 0, ro(i + 1)), 1'b0);
        check("credit_full", int'(rd_ready), 0);
        rd_en = 1'b1; rd_addr = 4'd5; pass_first = 1'b0; pass_last = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        check("credit_hold", int'(rd_ready), 0);
        check("stall_psum_hold", int'(psum_in), 0);
        check("full_out_valid", int'(out_valid), 1);
        rd_en = 1'b0;
        out_ready = 1'b1;
        for (int i = 4; i < 8; i++) issue(mk(8 + i, 1, 1, i + 1, 0, ro(i + 1)), 1'b0);
        drain();

        // Forwarding: write-back of 42 to addr 3 coincides with a read of addr 3
        issue(mk(3, 1, 0, 42, 0, 0), 1'b0);
        issue(mk(9, 1, 0, 0, 0, 0), 1'b0);
        issue(mk(10, 1, 0, 0, 0, 0), 1'b0);
        issue(mk(3, 0, 1, 1, 42, 43), 1'b0);
        drain();

        // Random downstream stalls with simultaneous push/pop, order preserved
        for (int i = 0; i < 12; i++) issue(mk(4 + (i % 4), 0, 1, i, 20, 20 + i), 1'b1);
        drain();

        // Reset with two results in the FIFO and three writes in flight
        out_ready = 1'b0;
        issue(mk(12, 1, 1, 7, 0, 7), 1'b0);
        issue(mk(13, 1, 1, 8, 0, 8), 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        check("pre_rst_valid", int'(out_valid), 1);
        for (int i = 0; i < 3; i++) issue(mk(i, 1, 0, 77, 0, 0), 1'b0);
        rstn = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_psum_in", int'(psum_in), 0);
        check("midrst_out_data", int'(out_data), 0);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        #1;
        check("post_rst_rd_ready", int'(rd_ready), 1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) issue(mk(i, 0, 1, 0, 20, 20), 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/psum_feed_buf.md
Name: psum_feed_buf

Overview:
Partial-sum feedback buffer on the other side of the conv-kernel psum adder tree.
- Supplies the psum_in operand to the adder tree and captures the tree's psum_out result a fixed latency later.
- Writes the result back to on-chip storage for the next input-channel pass, or drains it on the final pass through a valid/ready output FIFO.
- Sits between the kernel controller, one adder-tree column and the output writer.

Parameters:
DWIDTH, 25, psum width (matches adder tree).
DEPTH, 16, number of psum entries (output pixels per tile); AW = $clog2(DEPTH), local.
ADD_LAT, 2, adder-tree register stages from psum_in to psum_out.
OUT_DEPTH, 4, output FIFO entries (>=2).

Ports:
clk  in  1  clock
rstn  in  1  async reset, active-low
rd_en  in  1  controller issues a psum slot this cycle
rd_addr  in  AW  entry index
pass_first  in  1  qualifies rd_en: first input-channel pass, feed zero
pass_last  in  1  qualifies rd_en: last pass, result goes to output FIFO
rd_ready  out  1  issue accepted when rd_en && rd_ready
psum_in  out  DWIDTH signed  operand to adder tree
psum_ret  in  DWIDTH signed  adder tree psum_out
out_valid  out  1  output FIFO not empty
out_ready  in  1  downstream accepts
out_data  out  DWIDTH signed  FIFO head

Behaviour:
- Reset (rstn low, any time, async): psum_in=0, out_valid=0, out_data=0, FIFO empty, delay line cleared, rd_ready=1 after release. Mem contents not reset. Reset mid-pass drops all in-flight ops; nothing is written.
- Accept at cycle t:
  - psum_in is registered and valid in cycle t+1: value 0 if pass_first, else mem[rd_addr].
  - When not accepted, psum_in holds its previous value.
- Delay line: 1+ADD_LAT stages of {vld, addr, last}. In cycle t+1+ADD_LAT, psum_ret is sampled:
  - last=0: mem[addr] <= psum_ret at end of cycle.
  - last=1: psum_ret pushed into output FIFO.
- RAW forwarding: a read and a write-back to the same address in the same cycle return psum_ret, not stale mem. Read-after-write to an address whose write is still in the delay line (gap < 1+ADD_LAT cycles) is illegal; the controller guarantees it cannot occur. Not checked in RTL.
- Credit: rd_ready = (fifo_count + inflight_last) < OUT_DEPTH, where inflight_last = count of delay stages with vld&last. Applies to all issues, last or not. Guarantees the FIFO never overflows and psum_ret is never dropped.
- rd_en while rd_ready=0: ignored, no state change, psum_in holds.
- FIFO:
  - out_valid = count!=0; out_data = head (registered storage, first-word visible).
  - Pop on out_valid&&out_ready; push and pop in the same cycle keep count, legal even when full.
  - Order of outputs = order of last-pass issues.
- Throughput: one issue per cycle when rd_ready=1.
- pass_first && pass_last together: single-pass mode; psum_in=0, result goes straight to FIFO.
- Arithmetic: none inside the block (pure storage/routing); widths are DWIDTH throughout, no truncation.

Optional Feature:
PSUM_RELU_EN
- Defined: the value pushed into the output FIFO is clamped to 0 when psum_ret is negative (MSB=1). Write-back to mem is never clamped.
- Undefined: values are pushed unmodified.

Test Plan:
- Single-pass mode: issue addr 0..3 with first=last=1, tree returns 5,-7,100,0 -> psum_in=0 each cycle t+1; out_data sequence 5,-7,100,0 (with PSUM_RELU_EN: 5,0,100,0), out_ready=1.
- Three passes over addr 0..7 with the tree adding const 10 per pass -> final drained values 30 each, 8 outputs, psum_in on pass 2 reads 10 and on pass 3 reads 20.
- Backpressure: out_ready=0, stream 8 last-pass issues with OUT_DEPTH=4 -> rd_ready falls after 4 accepted, no FIFO overflow; out_ready=1 releases the remaining 4 in order.
- Forwarding: write-back to addr 3 with value 42 in the same cycle as an issue on addr 3 (non-first) -> psum_in=42 next cycle.
- Full FIFO with simultaneous pop and push -> count stays OUT_DEPTH, order preserved.
- Assert rstn low with 3 ops in flight and 2 in FIFO -> out_valid=0 immediately, psum_in=0, no mem write observed for in-flight addresses, rd_ready=1 after release.
